// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the system controller: FSM states, command opcodes
// and the fixed register-file addresses used for ALU operands.
package sys_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_RD_ADDR,
        S_RD_WAIT,
        S_RD_PUSH,
        S_OP_A,
        S_OP_B,
        S_ALU_FUN,
        S_GATE_WAIT,
        S_ALU_WAIT,
        S_PUSH_LO,
        S_PUSH_HI
    } state_e;

    localparam logic [7:0] CMD_WR      = 8'hAA;
    localparam logic [7:0] CMD_RD      = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam int ADDR_OPA = 0;
    localparam int ADDR_OPB = 1;

endpackage

// File: rtl/sys_ctrl_tx_push.sv
// Two-entry reply byte sequencer. Loaded with one or two bytes (low byte
// first), it drains one byte per cycle into the TX FIFO whenever the FIFO
// is not full. 'pop' tells the controller a byte is leaving this cycle.
module sys_ctrl_tx_push (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        load_two,
    input  logic [15:0] load_data,
    input  logic        fifo_full,
    output logic        pop,
    output logic [7:0]  fifo_wr_data,
    output logic        fifo_wr_inc
);

    logic [15:0] data_q, data_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        wr_inc_q, wr_inc_d;

    assign pop          = (cnt_q != 2'd0) && !fifo_full;
    assign fifo_wr_data = wr_data_q;
    assign fifo_wr_inc  = wr_inc_q;

    // Load or shift out the low entry; write data holds between pushes
    always_comb begin
        data_d    = data_q;
        cnt_d     = cnt_q;
        wr_data_d = wr_data_q;
        wr_inc_d  = 1'b0;
        if (load) begin
            data_d = load_data;
            cnt_d  = load_two ? 2'd2 : 2'd1;
        end else if (pop) begin
            wr_inc_d  = 1'b1;
            wr_data_d = data_q[7:0];
            data_d    = {8'h00, data_q[15:8]};
            cnt_d     = cnt_q - 2'd1;
        end
    end

    // Sequencer state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '0;
            cnt_q     <= '0;
            wr_data_q <= '0;
            wr_inc_q  <= 1'b0;
        end else begin
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            wr_data_q <= wr_data_d;
            wr_inc_q  <= wr_inc_d;
        end
    end

endmodule

// File: rtl/sys_ctrl.sv
// System controller: decodes the 4-command byte protocol from the RX
// synchronizer, drives the register file and the gated ALU, and queues
// reply bytes for the TX FIFO. Every output is a flop.
module sys_ctrl
    import sys_ctrl_pkg::*;
#(
    parameter int GATE_LAT = 3,
    parameter int ADDR_W   = 4
) (
    input  logic              REF_CLK,
    input  logic              RST,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic [7:0]        rd_data,
    input  logic              rd_data_valid,
    input  logic [15:0]       alu_out,
    input  logic              alu_out_valid,
    input  logic              fifo_full,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        wr_data,
    output logic              gate_en,
    output logic              alu_en,
    output logic [3:0]        alu_fun,
    output logic [7:0]        fifo_wr_data,
    output logic              fifo_wr_inc,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d, rd_en_q, rd_en_d;
    logic              gate_en_q, gate_en_d, alu_en_q, alu_en_d;
    logic [3:0]        alu_fun_q, alu_fun_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              load, load_two, pop;
    logic [15:0]       load_data;

    assign wr_en   = wr_en_q;
    assign rd_en   = rd_en_q;
    assign addr    = addr_q;
    assign wr_data = wr_data_q;
    assign gate_en = gate_en_q;
    assign alu_en  = alu_en_q;
    assign alu_fun = alu_fun_q;
    assign busy    = busy_q;

    // Next-state and registered-output decode; bytes arriving in
    // non-receiving states fall through the defaults and are dropped
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        gate_en_d = gate_en_q;
        alu_en_d  = 1'b0;
        alu_fun_d = alu_fun_q;
        cnt_d     = cnt_q;
        load      = 1'b0;
        load_two  = 1'b0;
        load_data = {8'h00, rd_data};
        case (state_q)
            S_IDLE: if (rx_valid) begin
                case (rx_data)
                    CMD_WR:      state_d = S_WR_ADDR;
                    CMD_RD:      state_d = S_RD_ADDR;
                    CMD_ALU_OP:  state_d = S_OP_A;
                    CMD_ALU_NOP: state_d = S_ALU_FUN;
                    default:     state_d = S_IDLE;
                endcase
            end
            S_WR_ADDR: if (rx_valid) begin
                addr_d  = rx_data[ADDR_W-1:0];
                state_d = S_WR_DATA;
            end
            S_WR_DATA: if (rx_valid) begin
                wr_en_d   = 1'b1;
                wr_data_d = rx_data;
                state_d   = S_IDLE;
            end
            S_RD_ADDR: if (rx_valid) begin
                rd_en_d = 1'b1;
                addr_d  = rx_data[ADDR_W-1:0];
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: if (rd_data_valid) begin
                load    = 1'b1;
                state_d = S_RD_PUSH;
            end
            S_RD_PUSH: if (pop) state_d = S_IDLE;
            S_OP_A: if (rx_valid) begin
                wr_en_d   = 1'b1;
                addr_d    = ADDR_W'(ADDR_OPA);
                wr_data_d = rx_data;
                state_d   = S_OP_B;
            end
            S_OP_B: if (rx_valid) begin
                wr_en_d   = 1'b1;
                addr_d    = ADDR_W'(ADDR_OPB);
                wr_data_d = rx_data;
                state_d   = S_ALU_FUN;
            end
            S_ALU_FUN: if (rx_valid) begin
                alu_fun_d = rx_data[3:0];
                gate_en_d = 1'b1;
                cnt_d     = 4'd0;
                state_d   = S_GATE_WAIT;
            end
            // Let the gated clock settle before firing the ALU
            S_GATE_WAIT: begin
                if (cnt_q == 4'(GATE_LAT)) begin
                    alu_en_d = 1'b1;
                    state_d  = S_ALU_WAIT;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_ALU_WAIT: if (alu_out_valid) begin
                load      = 1'b1;
                load_two  = 1'b1;
                load_data = alu_out;
                state_d   = S_PUSH_LO;
            end
            S_PUSH_LO: if (pop) state_d = S_PUSH_HI;
            S_PUSH_HI: if (pop) begin
                gate_en_d = 1'b0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // Controller registers; reset abandons any partial frame
    always_ff @(posedge REF_CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            gate_en_q <= 1'b0;
            alu_en_q  <= 1'b0;
            alu_fun_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            gate_en_q <= gate_en_d;
            alu_en_q  <= alu_en_d;
            alu_fun_q <= alu_fun_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
        end
    end

    sys_ctrl_tx_push u_tx_push (
        .clk          (REF_CLK),
        .rst_n        (RST),
        .load         (load),
        .load_two     (load_two),
        .load_data    (load_data),
        .fifo_full    (fifo_full),
        .pop          (pop),
        .fifo_wr_data (fifo_wr_data),
        .fifo_wr_inc  (fifo_wr_inc)
    );

endmodule

// File: tb/tb_sys_ctrl.sv
// Scoreboard bench for sys_ctrl: stimulus pushes expected strobe events,
// a negedge monitor pops and compares every strobe the DUT raises.
module tb_sys_ctrl;

    localparam int GATE_LAT = 3;
    localparam int ADDR_W   = 4;
    localparam int K_WR = 0, K_RD = 1, K_ALU = 2, K_PUSH = 3;

    typedef struct {
        int         kind;
        logic [7:0] a;
        logic [7:0] d;
    } ev_t;

    logic              REF_CLK = 1'b0;
    logic              RST = 1'b0;
    logic [7:0]        rx_data = '0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rd_data = '0;
    logic              rd_data_valid = 1'b0;
    logic [15:0]       alu_out = '0;
    logic              alu_out_valid = 1'b0;
    logic              fifo_full = 1'b0;
    logic              wr_en, rd_en, gate_en, alu_en, fifo_wr_inc, busy;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wr_data, fifo_wr_data;
    logic [3:0]        alu_fun;

    ev_t exp_q[$];
    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;
    int  rise_cyc = 0;
    int  push_seen = 0;
    logic gate_prev = 1'b0;
    logic full_at_edge = 1'b0;

    sys_ctrl #(.GATE_LAT(GATE_LAT), .ADDR_W(ADDR_W)) dut (
        .REF_CLK       (REF_CLK),
        .RST           (RST),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rd_data       (rd_data),
        .rd_data_valid (rd_data_valid),
        .alu_out       (alu_out),
        .alu_out_valid (alu_out_valid),
        .fifo_full     (fifo_full),
        .wr_en         (wr_en),
        .rd_en         (rd_en),
        .addr          (addr),
        .wr_data       (wr_data),
        .gate_en       (gate_en),
        .alu_en        (alu_en),
        .alu_fun       (alu_fun),
        .fifo_wr_data  (fifo_wr_data),
        .fifo_wr_inc   (fifo_wr_inc),
        .busy          (busy)
    );

    always #5 REF_CLK = ~REF_CLK;

    always @(posedge REF_CLK) begin
        cyc          <= cyc + 1;
        full_at_edge <= fifo_full;
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [7:0] a, input logic [7:0] d);
        ev_t e;
        e.kind = kind; e.a = a; e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input logic [7:0] a, input logic [7:0] d);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: got kind=%0d a=0x%0h d=0x%0h expected none", kind, a, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.a != a || e.d != d) begin
                fails++;
                $display("FAIL event: got kind=%0d a=0x%0h d=0x%0h expected kind=%0d a=0x%0h d=0x%0h",
                         kind, a, d, e.kind, e.a, e.d);
            end
        end
    endtask

    // Monitor: every strobe becomes an observed event
    always @(negedge REF_CLK) begin
        if (gate_en && !gate_prev) rise_cyc = cyc;
        gate_prev = gate_en;
        if (wr_en) observe(K_WR, 8'(addr), wr_data);
        if (rd_en) observe(K_RD, 8'(addr), 8'h00);
        if (alu_en) begin
            observe(K_ALU, 8'h00, 8'(alu_fun));
            check("alu_en_latency", cyc - rise_cyc, GATE_LAT + 1);
            check("gate_en_at_alu_en", int'(gate_en), 1);
        end
        if (fifo_wr_inc) begin
            push_seen++;
            observe(K_PUSH, 8'h00, fifo_wr_data);
            check("push_while_full", int'(full_at_edge), 0);
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge REF_CLK);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge REF_CLK);
        rx_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge REF_CLK);
        @(negedge REF_CLK);
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_alu();
        bit seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge REF_CLK);
            seen = alu_en;
        end
        check("alu_en_seen", int'(seen), 1);
    endtask

    initial begin
        int n0;
        #1;
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_rd_en", int'(rd_en), 0);
        check("rst_gate_en", int'(gate_en), 0);
        check("rst_alu_en", int'(alu_en), 0);
        check("rst_fifo_wr_inc", int'(fifo_wr_inc), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_addr", int'(addr), 0);
        check("rst_alu_fun", int'(alu_fun), 0);
        repeat (2) @(negedge REF_CLK);
        RST = 1'b1;

        // Register write
        expect_ev(K_WR, 8'h05, 8'h3C);
        send(8'hAA); send(8'h05); send(8'h3C);
        drain("wr_frame_done");
        check("wr_busy_low", int'(busy), 0);

        // Register read with one-byte reply
        expect_ev(K_RD, 8'h05, 8'h00);
        expect_ev(K_PUSH, 8'h00, 8'h3C);
        send(8'hBB);
        check("busy_after_cmd", int'(busy), 1);
        send(8'h05);
        rd_data = 8'h3C; rd_data_valid = 1'b1;
        @(negedge REF_CLK);
        rd_data_valid = 1'b0;
        drain("rd_frame_done");
        check("rd_busy_low", int'(busy), 0);

        // ALU with operands; stray byte during ALU_WAIT is dropped
        expect_ev(K_WR, 8'h00, 8'h0A);
        expect_ev(K_WR, 8'h01, 8'h14);
        expect_ev(K_ALU, 8'h00, 8'h00);
        expect_ev(K_PUSH, 8'h00, 8'h1E);
        expect_ev(K_PUSH, 8'h00, 8'h00);
        send(8'hCC); send(8'h0A); send(8'h14); send(8'h00);
        check("gate_en_rise", int'(gate_en), 1);
        wait_alu();
        send(8'h77);
        check("gate_en_alu_wait", int'(gate_en), 1);
        alu_out = 16'h001E; alu_out_valid = 1'b1;
        @(negedge REF_CLK);
        alu_out_valid = 1'b0;
        drain("alu_op_frame_done");
        check("gate_en_off", int'(gate_en), 0);
        check("alu_busy_low", int'(busy), 0);

        // ALU no-operand with FIFO backpressure
        expect_ev(K_ALU, 8'h00, 8'h02);
        expect_ev(K_PUSH, 8'h00, 8'hCD);
        expect_ev(K_PUSH, 8'h00, 8'hAB);
        send(8'hDD); send(8'h02);
        wait_alu();
        fifo_full = 1'b1; alu_out = 16'hABCD; alu_out_valid = 1'b1;
        n0 = push_seen;
        @(negedge REF_CLK);
        alu_out_valid = 1'b0;
        repeat (5) @(negedge REF_CLK);
        check("no_push_while_full", push_seen - n0, 0);
        fifo_full = 1'b0;
        drain("alu_nop_frame_done");
        check("nop_push_count", push_seen - n0, 2);

        // Unknown opcode ignored, then a normal write
        expect_ev(K_WR, 8'h03, 8'h99);
        send(8'h55);
        check("unknown_busy", int'(busy), 0);
        send(8'hAA); send(8'h03); send(8'h99);
        drain("after_unknown_done");

        // Reset in GATE_WAIT, then recovery
        expect_ev(K_WR, 8'h00, 8'h01);
        expect_ev(K_WR, 8'h01, 8'h02);
        send(8'hCC); send(8'h01); send(8'h02); send(8'h05);
        @(negedge REF_CLK);
        check("gate_wait_gate_en", int'(gate_en), 1);
        drain("pre_reset_writes");
        RST = 1'b0;
        #1;
        check("mid_rst_gate_en", int'(gate_en), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_alu_en", int'(alu_en), 0);
        repeat (6) @(negedge REF_CLK);
        RST = 1'b1;
        repeat (6) @(negedge REF_CLK);
        check("post_rst_gate_en", int'(gate_en), 0);
        expect_ev(K_WR, 8'h07, 8'h42);
        send(8'hAA); send(8'h07); send(8'h42);
        drain("post_reset_frame_done");
        check("post_rst_busy", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
